cpu_controller: RTL and testbench

- Instruction sequencer for the VeriRISC CPU; sits directly upstream of the ALU, accumulator, PC, IR and memory interface.
- Steps through a fixed 8-phase cycle per instruction and decodes the IR opcode plus the ALU `zero` flag into load, select and enable strobes.
- Clocked on the posedge. The ALU samples on the negedge, so the ALU result computed in ALU_OP is stable before `ld_ac` captures it at the end of STORE.

---
 rtl/typedefs.sv | 32 +++
 rtl/cpu_controller.sv | 115 +++++++++++
 tb/tb_cpu_controller.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/typedefs.sv
// Shared CPU type definitions: IR opcode encoding and the controller state set.
package typedefs;

  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  typedef enum logic [3:0] {
    INST_ADDR,
    INST_FETCH,
    INST_LOAD,
    IDLE,
    OP_ADDR,
    OP_FETCH,
    ALU_OP,
    STORE,
    HALTED
  } ctrl_state_t;

  // Opcodes whose result lands in the accumulator via the ALU.
  function automatic logic is_aluop(input opcode_t op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/cpu_controller.sv
// VeriRISC instruction sequencer: 8-phase cycle, decodes opcode/zero into strobes.
// Optional retired-instruction counter enabled by defining CTRL_INSTR_CNT_EN.
module cpu_controller
  import typedefs::*;
#(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic    clk,
  input  logic    rst,
  input  opcode_t opcode,
  input  logic    zero,
  output logic    sel,
  output logic    rd,
  output logic    ld_ir,
  output logic    inc_pc,
  output logic    halt,
  output logic    ld_pc,
  output logic    data_e,
  output logic    ld_ac,
  output logic    wr
`ifdef CTRL_INSTR_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] instr_count
`endif
);

  ctrl_state_t state;
  logic        aluop;

  if (CNT_WIDTH < 1) begin : g_bad_cnt_width
    $error("cpu_controller: CNT_WIDTH must be at least 1");
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INST_ADDR;
    end else begin
      case (state)
        INST_ADDR:  state <= INST_FETCH;
        INST_FETCH: state <= INST_LOAD;
        INST_LOAD:  state <= IDLE;
        IDLE:       state <= OP_ADDR;
        OP_ADDR:    state <= (opcode == HLT) ? HALTED : OP_FETCH;
        OP_FETCH:   state <= ALU_OP;
        ALU_OP:     state <= STORE;
        STORE:      state <= INST_ADDR;
        HALTED:     state <= HALTED;
        default:    state <= INST_ADDR;
      endcase
    end
  end

`ifdef CTRL_INSTR_CNT_EN
  // HLT never reaches STORE, so it is never counted and the count freezes.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_count <= '0;
    end else if (state == STORE) begin
      instr_count <= instr_count + 1'b1;
    end
  end
`endif

  assign aluop = is_aluop(opcode);

  // Strobes follow the current state directly so they line up with the datapath phase.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    halt   = 1'b0;
    ld_pc  = 1'b0;
    data_e = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    case (state)
      INST_ADDR: sel = 1'b1;
      INST_FETCH: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      INST_LOAD, IDLE: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      OP_ADDR: begin
        inc_pc = 1'b1;
        halt   = (opcode == HLT);
      end
      OP_FETCH: rd = aluop;
      ALU_OP: begin
        rd     = aluop;
        inc_pc = (opcode == SKZ) && zero;
        ld_pc  = (opcode == JMP);
        data_e = (opcode == STO);
      end
      STORE: begin
        rd     = aluop;
        ld_ac  = aluop;
        ld_pc  = (opcode == JMP);
        data_e = (opcode == STO);
        wr     = (opcode == STO);
      end
      HALTED: halt = 1'b1;
      default: ;
    endcase
  end

  a_wr_needs_data_e: assert property (@(posedge clk) disable iff (rst) wr |-> data_e);
  a_pc_exclusive:    assert property (@(posedge clk) disable iff (rst) !(ld_pc && inc_pc));
  a_rd_wr_exclusive: assert property (@(posedge clk) disable iff (rst) !(rd && wr));

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: directed instruction sequences then random opcode/zero/reset,
// all checked each cycle against a phase-counter reference model.
module tb_cpu_controller;
  import typedefs::*;

  logic    clk = 1'b0;
  logic    rst;
  opcode_t opcode;
  logic    zero;
  logic    sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;
`ifdef CTRL_INSTR_CNT_EN
  logic [3:0] instr_count;
`endif

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  // Reference model: instruction phase 0..7, halted flag, retired count.
  int unsigned m_phase  = 0;
  bit          m_halted = 1'b0;
  int unsigned m_count  = 0;

  always #5 clk = ~clk;

  cpu_controller #(.CNT_WIDTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .opcode (opcode),
    .zero   (zero),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .halt   (halt),
    .ld_pc  (ld_pc),
    .data_e (data_e),
    .ld_ac  (ld_ac),
    .wr     (wr)
`ifdef CTRL_INSTR_CNT_EN
    ,
    .instr_count (instr_count)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s phase=%0d halted=%0d op=%s: got %0h expected %0h",
               tag, m_phase, m_halted, opcode.name(), obs, exp);
    end
  endtask

  // Expected {sel,rd,ld_ir,inc_pc,halt,ld_pc,data_e,ld_ac,wr} from the strobe table.
  function automatic logic [8:0] exp_strobes(input int unsigned ph, input bit hlt,
                                             input opcode_t op, input logic z);
    bit alu = (op == ADD || op == AND || op == XOR || op == LDA);
    bit s = 0, r = 0, li = 0, ip = 0, h = 0, lp = 0, de = 0, la = 0, w = 0;
    if (hlt) h = 1;
    else begin
      case (ph)
        0: s = 1;
        1: begin s = 1; r = 1; end
        2, 3: begin s = 1; r = 1; li = 1; end
        4: begin ip = 1; h = (op == HLT); end
        5: r = alu;
        6: begin r = alu; ip = (op == SKZ) && z; lp = (op == JMP); de = (op == STO); end
        default: begin
          r = alu; la = alu; lp = (op == JMP); de = (op == STO); w = (op == STO);
        end
      endcase
    end
    return {s, r, li, ip, h, lp, de, la, w};
  endfunction

  function automatic ctrl_state_t exp_state(input int unsigned ph, input bit hlt);
    if (hlt) return HALTED;
    case (ph)
      0: return INST_ADDR;
      1: return INST_FETCH;
      2: return INST_LOAD;
      3: return IDLE;
      4: return OP_ADDR;
      5: return OP_FETCH;
      6: return ALU_OP;
      default: return STORE;
    endcase
  endfunction

  // One clock: drive after negedge, check, then advance the model over the posedge.
  task automatic step(input logic r, input opcode_t op, input logic z);
    @(negedge clk);
    rst = r; opcode = op; zero = z;
    #1;
    check_eq("strobes", {23'd0, sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr},
             {23'd0, exp_strobes(m_phase, m_halted, op, z)});
    check_eq("state", {28'd0, dut.state}, {28'd0, exp_state(m_phase, m_halted)});
`ifdef CTRL_INSTR_CNT_EN
    check_eq("instr_count", {28'd0, instr_count}, m_count % 16);
`endif
    @(posedge clk);
    if (r) begin
      m_phase = 0; m_halted = 1'b0; m_count = 0;
    end else if (!m_halted) begin
      if (m_phase == 4 && op == HLT) m_halted = 1'b1;
      else begin
        if (m_phase == 7) m_count++;
        m_phase = (m_phase + 1) % 8;
      end
    end
  endtask

  task automatic run_instr(input opcode_t op, input logic [7:0] zpat);
    for (int i = 0; i < 8; i++) step(1'b0, op, zpat[i]);
  endtask

  initial begin
    rst = 1'b1; opcode = HLT; zero = 1'b0;
    @(posedge clk);
    @(posedge clk);
    m_phase = 0; m_halted = 1'b0; m_count = 0;

    step(1'b1, LDA, 1'b0);
    run_instr(LDA, 8'h00);
    run_instr(STO, 8'h00);
    run_instr(SKZ, 8'hFF);
    run_instr(SKZ, 8'b1010_0000);  // zero high only outside ALU_OP
    run_instr(SKZ, 8'b0010_1111);
    run_instr(JMP, 8'h55);
    run_instr(ADD, 8'h00);
    run_instr(AND, 8'h00);
    run_instr(XOR, 8'h00);
    for (int i = 0; i < 5; i++) step(1'b0, HLT, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, opcode_t'($urandom_range(7)), 1'($urandom));
    step(1'b1, HLT, 1'b0);
    step(1'b0, LDA, 1'b0);

    // 17 ADDs wrap a 4-bit counter to 1, then reset lands mid-OP_FETCH.
    step(1'b1, ADD, 1'b0);
    for (int i = 0; i < 17; i++) run_instr(ADD, 8'h00);
    for (int i = 0; i < 5; i++) step(1'b0, ADD, 1'b0);
    step(1'b1, ADD, 1'b0);
    step(1'b0, ADD, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      opcode_t op = opcode_t'($urandom_range(7));
      if (op == HLT && $urandom_range(3) != 0) op = ADD;
      step(($urandom_range(79) == 0) ? 1'b1 : 1'b0, op, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
